// File: rtl/load_store_unit_if.sv
// Word-wide req/ack memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage after the ALU: one load or store per request over a req/ack bus,
// with alignment/funct3 checking, byte-lane steering, load extension and bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       is_store_i,
    input  logic [2:0]                 funct3_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                wdata_i,
    load_store_unit_if.master          mem,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [31:0]                rdata_o,
    output logic                       misaligned_o,
    output logic                       bus_err_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       off_q;
    logic [2:0]       funct3_q;
    logic             busy_q, done_q, misaligned_q, bus_err_q;
    logic [31:0]      rdata_q;
    logic             mem_req_q, mem_we_q;
    logic [31:0]      mem_addr_q, mem_wdata_q;
    logic [3:0]       mem_be_q;

    logic             legal_s, aligned_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;

    // Pick the byte/half addressed by off out of the bus word and extend per funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = d;
        endcase
    endfunction

    // Request decode: legality, alignment and store lane steering from the live inputs.
    always_comb begin
        legal_s   = 1'b0;
        aligned_s = 1'b1;
        be_s      = 4'b1111;
        wdata_s   = 32'd0;
        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = ~is_store_i;
            default:                legal_s = 1'b0;
        endcase
        case (funct3_i[1:0])
            2'b01:   aligned_s = (addr_i[0] == 1'b0);
            2'b10:   aligned_s = (addr_i[1:0] == 2'b00);
            default: aligned_s = 1'b1;
        endcase
        if (is_store_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << addr_i[1:0];
                    wdata_s = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = wdata_i;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = 32'd0;
        end
    end

    // Control FSM; every output is a flop so the bus is stable for the whole REQ phase.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= 2'd0;
            funct3_q     <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            rdata_q      <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (legal_s && aligned_s) begin
                            state_q     <= ST_REQ;
                            cnt_q       <= '0;
                            off_q       <= addr_i[1:0];
                            funct3_q    <= funct3_i;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_be_q    <= be_s;
                            mem_wdata_q <= wdata_s;
                        end else begin
                            state_q      <= ST_FIN;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so an ack on the final counted cycle still succeeds.
                    if (mem.mem_ack || (cnt_q == CNT_LAST)) begin
                        state_q     <= ST_FIN;
                        done_q      <= 1'b1;
                        bus_err_q   <= ~mem.mem_ack;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= 32'd0;
                        mem_be_q    <= 4'd0;
                        mem_wdata_q <= 32'd0;
                        if (mem.mem_ack && !mem_we_q) begin
                            rdata_q <= load_extend(mem.mem_rdata, off_q, funct3_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign misaligned_o  = misaligned_q;
    assign bus_err_o     = bus_err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule
